// File: rtl/shifter_pkg.sv
// Shared op encodings and depth helper for pipelined_barrel_shifter.
// The rotate op is only implemented when SHIFTER_ROTATE_EN is defined.
package shifter_pkg;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } shift_op_e;

  function automatic int shiftDepth(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One 2^K shift level of the barrel shifter plus its pipeline register.
// With SHIFTER_ROTATE_EN undefined, OP_ROR is handled as a logical right shift.
module shift_stage
  import shifter_pkg::*;
#(
  parameter  int N = 32,
  parameter  int K = 0,
  localparam int M = shiftDepth(N)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          hold_i,
  input  logic          valid_i,
  input  logic [N-1:0]  data_i,
  input  shift_op_e     op_i,
  input  logic [M-1:0]  shamt_i,
  input  logic          sign_i,
  output logic          valid_o,
  output logic [N-1:0]  data_o,
  output shift_op_e     op_o,
  output logic [M-1:0]  shamt_o,
  output logic          sign_o
);

  localparam int S = 1 << K;

  logic [N-1:0] data_d, data_q;
  logic         valid_q, sign_q;
  shift_op_e    op_q;
  logic [M-1:0] shamt_q;

  // SRA fills from the operand's original sign, not from this stage's MSB.
  always_comb begin
    data_d = data_i;
    if (shamt_i[K]) begin
      case (op_i)
        OP_SLL:  data_d = data_i << S;
        OP_SRL:  data_d = data_i >> S;
        OP_SRA:  data_d = {{S{sign_i}}, data_i[N-1:S]};
`ifdef SHIFTER_ROTATE_EN
        OP_ROR:  data_d = {data_i[S-1:0], data_i[N-1:S]};
`else
        OP_ROR:  data_d = data_i >> S;
`endif
        default: data_d = data_i;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      op_q    <= OP_SLL;
      shamt_q <= '0;
      sign_q  <= 1'b0;
    end else if (!hold_i) begin
      valid_q <= valid_i;
      data_q  <= data_d;
      op_q    <= op_i;
      shamt_q <= shamt_i;
      sign_q  <= sign_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign op_o    = op_q;
  assign shamt_o = shamt_q;
  assign sign_o  = sign_q;

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Fully pipelined barrel shifter: M = log2(N) shift_stage levels, one op per cycle.
// Define SHIFTER_ROTATE_EN to enable rotate-right on op 11.
module pipelined_barrel_shifter
  import shifter_pkg::*;
#(
  parameter  int N = 32,
  localparam int M = shiftDepth(N)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic [M-1:0]  in_shamt,
  input  logic [1:0]    in_op,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data
);

  logic         chainValid [M+1];
  logic [N-1:0] chainData  [M+1];
  shift_op_e    chainOp    [M+1];
  logic [M-1:0] chainShamt [M+1];
  logic         chainSign  [M+1];
  logic         stall;

  // A single global stall freezes every stage so bubbles are kept in place.
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall & ~reset;

  assign chainValid[0] = in_valid & in_ready;
  assign chainData[0]  = in_data;
  assign chainOp[0]    = shift_op_e'(in_op);
  assign chainShamt[0] = in_shamt;
  assign chainSign[0]  = in_data[N-1];

  for (genvar k = 0; k < M; k++) begin : g_stage
    shift_stage #(
      .N (N),
      .K (k)
    ) u_stage (
      .clock   (clock),
      .reset   (reset),
      .hold_i  (stall),
      .valid_i (chainValid[k]),
      .data_i  (chainData[k]),
      .op_i    (chainOp[k]),
      .shamt_i (chainShamt[k]),
      .sign_i  (chainSign[k]),
      .valid_o (chainValid[k+1]),
      .data_o  (chainData[k+1]),
      .op_o    (chainOp[k+1]),
      .shamt_o (chainShamt[k+1]),
      .sign_o  (chainSign[k+1])
    );
  end

  assign out_valid = chainValid[M];
  assign out_data  = chainData[M];

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Scoreboard bench for pipelined_barrel_shifter (N=32); honours SHIFTER_ROTATE_EN.
module tb_pipelined_barrel_shifter;
  import shifter_pkg::*;

  localparam int N = 32;
  localparam int M = 5;

  logic          clock;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic [M-1:0]  in_shamt;
  logic [1:0]    in_op;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_data;

  typedef struct {
    logic [N-1:0] expData;
    int           inCycle;
    int           stallSnap;
  } sb_entry_t;

  sb_entry_t    sbQ [$];
  int           checkCount = 0;
  int           passCount  = 0;
  int           cycle      = 0;
  int           stallCount = 0;
  logic         drvUseExp  = 1'b0;
  logic [N-1:0] drvExp     = '0;

  pipelined_barrel_shifter #(.N(N)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cycle++;

  // Reference: whole-word shifts straight from the op definitions.
  function automatic logic [N-1:0] refShift(input logic [N-1:0] d, input logic [M-1:0] s,
                                            input logic [1:0] op);
    case (op)
      2'b00:   return d << s;
      2'b01:   return d >> s;
      2'b10:   return $unsigned($signed(d) >>> s);
`ifdef SHIFTER_ROTATE_EN
      default: return (s == 0) ? d : ((d >> s) | (d << (6'd32 - {1'b0, s})));
`else
      default: return d >> s;
`endif
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%h, expected 0x%h (cycle %0d)", name, act, exp, cycle);
  endtask

  // Input-side recorder: every accepted operand pushes its expected result.
  always @(negedge clock) begin
    if (!reset && in_valid && in_ready) begin
      sbQ.push_back('{drvUseExp ? drvExp : refShift(in_data, in_shamt, in_op), cycle, stallCount});
    end
  end

  // Output-side monitor: handshake rules, ordering, data and latency.
  always @(negedge clock) begin
    sb_entry_t e;
    if (reset) begin
      sbQ.delete();
      checkOutput("in_ready_in_reset", {31'b0, in_ready}, 32'd0);
    end else begin
      checkOutput("in_ready", {31'b0, in_ready}, {31'b0, !(out_valid && !out_ready)});
      if (out_valid && sbQ.size() == 0) begin
        checkOutput("spurious_out_valid", {31'b0, out_valid}, 32'd0);
      end else if (out_valid && out_ready) begin
        e = sbQ.pop_front();
        checkOutput("out_data", out_data, e.expData);
        checkOutput("latency", 32'(cycle - e.inCycle), 32'(M + stallCount - e.stallSnap));
      end
      if (out_valid && !out_ready) stallCount++;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the operand was accepted.
  task automatic applyStimulus(input logic [N-1:0] d, input logic [M-1:0] s, input logic [1:0] op,
                               input logic [N-1:0] exp);
    logic accepted = 1'b0;
    in_data   = d;
    in_shamt  = s;
    in_op     = op;
    drvExp    = exp;
    drvUseExp = 1'b1;
    in_valid  = 1'b1;
    for (int t = 0; t < 50 && !accepted; t++) begin
      @(negedge clock);
      accepted = in_ready;
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
    checkOutput("accepted", {31'b0, accepted}, 32'd1);
  endtask

  task automatic waitDrain();
    for (int t = 0; t < 100 && sbQ.size() != 0; t++) begin
      @(posedge clock);
      #1;
    end
    checkOutput("drained", 32'(sbQ.size()), 32'd0);
  endtask

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [N-1:0] d;
    logic [M-1:0] s;
    logic [1:0]   op;
    logic         pending;
    int           issued;
    int           loops;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shamt  = '0;
    in_op     = 2'b00;
    out_ready = 1'b1;

    repeat (2) @(posedge clock);
    #1;
    @(negedge clock);
    checkOutput("reset_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("reset_out_data", out_data, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    $display("[TB] directed shifts");
    applyStimulus(32'h0000_0001, 5'd31, OP_SLL, 32'h8000_0000);
    waitDrain();
    applyStimulus(32'h8000_0000, 5'd4, OP_SRL, 32'h0800_0000);
    applyStimulus(32'h8000_0000, 5'd4, OP_SRA, 32'hF800_0000);
    applyStimulus(32'h7000_0000, 5'd4, OP_SRA, 32'h0700_0000);
    applyStimulus(32'h8000_0000, 5'd31, OP_SRA, 32'hFFFF_FFFF);
    applyStimulus(32'h7FFF_FFFF, 5'd31, OP_SRA, 32'h0000_0000);
`ifdef SHIFTER_ROTATE_EN
    applyStimulus(32'h0000_0001, 5'd1, OP_ROR, 32'h8000_0000);
`else
    applyStimulus(32'h0000_0001, 5'd1, OP_ROR, 32'h0000_0000);
`endif
    for (int i = 0; i < 4; i++) begin
      applyStimulus(32'hDEAD_BEEF, 5'd0, 2'(i), 32'hDEAD_BEEF);
    end
    waitDrain();

    $display("[TB] stream of 8 with 3-cycle output stall");
    fork
      begin
        repeat (6) @(posedge clock);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1 out_ready = 1'b1;
      end
    join_none
    for (int i = 0; i < 8; i++) begin
      d  = 32'h1234_5678 + 32'(i) * 32'h0F0F_1111;
      s  = 5'(i * 3 + 1);
      op = 2'(i);
      applyStimulus(d, s, op, refShift(d, s, op));
    end
    waitDrain();

    $display("[TB] reset with ops in flight");
    applyStimulus(32'hAAAA_0001, 5'd2, OP_SLL, 32'hAAA8_0004);
    applyStimulus(32'h8000_00F0, 5'd3, OP_SRA, 32'hF000_001E);
    applyStimulus(32'h0000_FF00, 5'd8, OP_SRL, 32'h0000_00FF);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    checkOutput("post_reset_out_valid", {31'b0, out_valid}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      checkOutput("idle_out_valid", {31'b0, out_valid}, 32'd0);
    end
    @(posedge clock);
    #1;
    applyStimulus(32'h0000_000F, 5'd4, OP_SLL, 32'h0000_00F0);
    waitDrain();

    $display("[TB] randomized ops with valid/ready toggling");
    drvUseExp = 1'b0;
    pending   = 1'b0;
    issued    = 0;
    loops     = 0;
    while (issued < 10000 && loops < 60000) begin
      if (!pending && $urandom_range(0, 9) < 7) begin
        in_data  = $urandom;
        in_shamt = 5'($urandom_range(0, 31));
        in_op    = 2'($urandom_range(0, 3));
        pending  = 1'b1;
      end
      in_valid  = pending;
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clock);
      if (pending && in_ready) begin
        pending = 1'b0;
        issued++;
      end
      @(posedge clock);
      #1;
      loops++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checkOutput("random_issued", 32'(issued), 32'd10000);
    waitDrain();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
- Parametrised, fully pipelined barrel shifter for the ALU/execute path.
- Supports logical left, logical right and arithmetic right shifts, plus optional rotate-right.
- One shift level per log2 stage, each followed by a pipeline register; sustains one operation per cycle.
- Valid/ready handshake on both sides; a global stall provides backpressure.

Parameters:
- N, 32, data width in bits (power of two, ≥ 4).
- M, $clog2(N), shift-amount width and pipeline depth; derived, not overridden.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand presented this cycle.
- in_ready  output  1  shifter accepts the operand this cycle.
- in_data  input  N  operand.
- in_shamt  input  M  shift amount, 0..N-1.
- in_op  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROR.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_data  output  N  shifted result.

Behaviour:
- Reset (synchronous, clock edge with reset=1):
  - All stage valid bits, data, op and shamt registers clear to 0.
  - out_valid=0, out_data=0.
  - in_ready is held 0 while reset is high.
- Stall:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall & ~reset.
  - Transfer on the input side when in_valid & in_ready; on the output side when out_valid & out_ready.
- Pipeline:
  - Stage k (0..M-1) applies a shift of 2^k when the captured shamt[k]=1, otherwise passes data through.
  - Results are registered after each stage.
  - Latency is exactly M cycles from input transfer to out_valid, absent stalls. Throughput is 1/cycle.
- Stall semantics:
  - While stall=1, every stage register holds: data, op, shamt and valid.
  - Bubbles are not collapsed; held results are never dropped or duplicated.
- Fill rules:
  - SLL: zero-fill from the LSB.
  - SRL: zero-fill from the MSB.
  - SRA: fill with the operand's original MSB (sign), carried down the pipe alongside the data.
  - ROR: bits shifted out of the LSB re-enter at the MSB.
- Boundaries:
  - shamt=0 returns in_data unchanged for every op.
  - shamt=N-1 for SRA yields all-sign bits, except the LSB, which equals the original MSB.
  - in_valid=0 inserts a bubble; output side sees out_valid=0 M cycles later.
  - A simultaneous input transfer and output transfer in the same cycle is legal; the pipe advances by one.
- Reset mid-operation:
  - All in-flight operations are discarded.
  - out_valid falls on the first edge with reset=1.
  - No result from before reset ever appears afterwards.
- Width rule: in_shamt is exactly M bits, so no out-of-range amounts exist.

Optional Feature:
- Macro SHIFTER_ROTATE_EN.
- Defined: op 11 performs rotate-right by shamt.
- Undefined:
  - Rotate logic is not compiled.
  - op 11 behaves exactly as SRL (zero-fill).
  - Port list is unchanged.

Decomposition:
- Package shifter_pkg:
  - 2-bit op encodings: OP_SLL, OP_SRL, OP_SRA, OP_ROR.
  - Helper function to compute M from N.
- Sub-module shift_stage, parameters N and K (level):
  - One 2^K shift level with its mux logic and pipeline register (data, op, remaining shamt, sign, valid).
  - Has a hold input driven by the top-level stall.
- Top level: instantiates M shift_stage copies via generate, plus the handshake logic.

Test Plan (all with N=32, M=5):
- SLL 0x0000_0001 by 31 with out_ready=1 -> out_data 0x8000_0000, out_valid exactly 5 cycles after transfer.
- SRL 0x8000_0000 by 4 -> 0x0800_0000. SRA same operand and amount -> 0xF800_0000. SRA 0x7000_0000 by 4 -> 0x0700_0000.
- Back-to-back stream of 8 ops, then out_ready=0 for 3 cycles mid-stream:
  - in_ready=0 during the stall.
  - All 8 results emerge in order with correct values; none lost or duplicated.
- Assert reset for 1 cycle while 3 ops are in flight -> out_valid=0 the next cycle and stays 0 until new ops are issued; new op result correct after 5 cycles.
- ROR 0x0000_0001 by 1 -> 0x8000_0000 with SHIFTER_ROTATE_EN defined; 0x0000_0000 without it.
- shamt=0 for every op on 0xDEAD_BEEF -> 0xDEAD_BEEF; randomized 10k ops checked against a reference model, including random in_valid/out_ready toggling.
